// File: rtl/key_event_pkg.sv
// Shared definitions for the key event detector: FSM state encoding and
// default timing constants.
package key_event_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_HOLD  = 2'd2
  } key_fsm_state_t;

  localparam int DEF_TICK_DIV = 12000;
  localparam int DEF_LONG_T   = 1000;
  localparam int DEF_REPEAT_T = 200;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_event_fsm.sv
// Per-key press classifier: short press, long press and auto-repeat, all
// timed in prescaler ticks and delivered as registered one-cycle pulses.
module key_event_fsm
  import key_event_pkg::*;
#(
  parameter int LONG_T   = DEF_LONG_T,
  parameter int REPEAT_T = DEF_REPEAT_T,
  parameter int CNT_W    = $clog2(max_int(LONG_T, REPEAT_T) + 1)
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic tick,
  input  logic key_level,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic hold_state
);

  key_fsm_state_t state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic short_reg, short_next;
  logic long_reg, long_next;
  logic repeat_reg, repeat_next;
  logic hold_reg, hold_next;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      short_reg  <= 1'b0;
      long_reg   <= 1'b0;
      repeat_reg <= 1'b0;
      hold_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      short_reg  <= short_next;
      long_reg   <= long_next;
      repeat_reg <= repeat_next;
      hold_reg   <= hold_next;
    end
  end

  // Release is tested before the tick so it wins over a same-cycle threshold.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    short_next  = 1'b0;
    long_next   = 1'b0;
    repeat_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!key_level) begin
          state_next = ST_PRESS;
          cnt_next   = '0;
        end
      end
      ST_PRESS: begin
        if (key_level) begin
          short_next = 1'b1;
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (tick) begin
          if (cnt_reg == CNT_W'(LONG_T - 1)) begin
            long_next  = 1'b1;
            state_next = ST_HOLD;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (key_level) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (tick) begin
          if (cnt_reg == CNT_W'(REPEAT_T - 1)) begin
            repeat_next = 1'b1;
            cnt_next    = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
    hold_next = (state_next == ST_HOLD);
  end

  assign short_pulse  = short_reg;
  assign long_pulse   = long_reg;
  assign repeat_pulse = repeat_reg;
  assign hold_state   = hold_reg;

endmodule

// File: rtl/key_event.sv
// Multi-key event detector: one shared tick prescaler feeding an
// independent press classifier per key.
module key_event
  import key_event_pkg::*;
#(
  parameter int NKEY     = 3,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int LONG_T   = DEF_LONG_T,
  parameter int REPEAT_T = DEF_REPEAT_T
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [NKEY-1:0] key_state,
  output logic [NKEY-1:0] short_pulse,
  output logic [NKEY-1:0] long_pulse,
  output logic [NKEY-1:0] repeat_pulse,
  output logic [NKEY-1:0] hold_state
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PRE_W-1:0] presc_reg;
  logic             tick;

  assign tick = (presc_reg == PRE_W'(TICK_DIV - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in || tick) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NKEY; gi++) begin : g_key
      key_event_fsm #(
        .LONG_T   (LONG_T),
        .REPEAT_T (REPEAT_T)
      ) u_fsm (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .tick         (tick),
        .key_level    (key_state[gi]),
        .short_pulse  (short_pulse[gi]),
        .long_pulse   (long_pulse[gi]),
        .repeat_pulse (repeat_pulse[gi]),
        .hold_state   (hold_state[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_key_event.sv
// Scoreboard bench for key_event: expected pulses (cycle, key, kind) are queued
// by the stimulus and popped by a monitor whenever any pulse output is high.
module tb_key_event;

  localparam int NKEY = 3;
  localparam int K_SHORT = 0, K_LONG = 1, K_REPEAT = 2;

  logic clk_in = 1'b0;
  logic rst_in;
  logic [NKEY-1:0] key_state;
  logic [NKEY-1:0] short_pulse, long_pulse, repeat_pulse, hold_state;

  always #5 clk_in = ~clk_in;

  key_event #(
    .NKEY     (NKEY),
    .TICK_DIV (4),
    .LONG_T   (10),
    .REPEAT_T (3)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .key_state    (key_state),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .hold_state   (hold_state)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Edges since the last edge that sampled reset; ticks land on cyc = 4, 8, ...
  always @(posedge clk_in) begin
    if (rst_in) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc=%0d)", name, act, req, cyc);
    end
  endtask

  typedef struct {
    int cyc;
    int key;
    int kind;
  } ev_t;

  ev_t sb[$];

  task automatic expect_ev(input int c, input int k, input int kind);
    ev_t e;
    e.cyc  = c;
    e.key  = k;
    e.kind = kind;
    sb.push_back(e);
  endtask

  // Monitor
  logic [NKEY-1:0] prev_s = '0, prev_l = '0, prev_r = '0;
  ev_t got;

  always @(negedge clk_in) begin
    for (int k = 0; k < NKEY; k++) begin
      if (short_pulse[k] || long_pulse[k] || repeat_pulse[k]) begin
        check("pulse_onehot",
              int'(short_pulse[k]) + int'(long_pulse[k]) + int'(repeat_pulse[k]), 1);
        check("pulse_width",
              int'((short_pulse[k] & prev_s[k]) | (long_pulse[k] & prev_l[k]) |
                   (repeat_pulse[k] & prev_r[k])), 0);
      end
      for (int kind = 0; kind < 3; kind++) begin
        if ((kind == K_SHORT && short_pulse[k]) || (kind == K_LONG && long_pulse[k]) ||
            (kind == K_REPEAT && repeat_pulse[k])) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse: key=%0d kind=%0d at cyc=%0d, none expected",
                     k, kind, cyc);
          end else begin
            got = sb.pop_front();
            check("ev_cyc", cyc, got.cyc);
            check("ev_key", k, got.key);
            check("ev_kind", kind, got.kind);
          end
        end
      end
    end
    prev_s <= short_pulse;
    prev_l <= long_pulse;
    prev_r <= repeat_pulse;
  end

  task automatic do_reset();
    @(negedge clk_in);
    rst_in    = 1'b1;
    key_state = '1;
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    int guard = 0;
    while (cyc < c && guard < 1000) begin
      @(negedge clk_in);
      guard++;
    end
    check("wait_cyc", cyc, c);
  endtask

  task automatic drain();
    repeat (3) @(negedge clk_in);
    check("sb_empty", sb.size(), 0);
    sb.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_short"},  int'(short_pulse),  0);
    check({tag, "_long"},   int'(long_pulse),   0);
    check({tag, "_repeat"}, int'(repeat_pulse), 0);
    check({tag, "_hold"},   int'(hold_state),   0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in    = 1'b1;
    key_state = '1;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    check_all_zero("reset");

    // Short press on key0: press sampled at edge 1, release at edge 21
    do_reset();
    key_state[0] = 1'b0;
    expect_ev(21, 0, K_SHORT);
    wait_cyc(20);
    key_state[0] = 1'b1;
    wait_cyc(30);
    drain();

    // Long hold on key1: long at 40, repeats at 52 and 64, release at 71
    do_reset();
    key_state[1] = 1'b0;
    expect_ev(40, 1, K_LONG);
    expect_ev(52, 1, K_REPEAT);
    expect_ev(64, 1, K_REPEAT);
    wait_cyc(39);
    check("hold1_before_long", int'(hold_state[1]), 0);
    wait_cyc(40);
    check("hold1_at_long", int'(hold_state[1]), 1);
    wait_cyc(70);
    check("hold1_late", int'(hold_state[1]), 1);
    key_state[1] = 1'b1;
    wait_cyc(71);
    check("hold1_released", int'(hold_state[1]), 0);
    wait_cyc(80);
    drain();

    // Key2 released on the same edge as the 10th tick: short wins
    do_reset();
    key_state[2] = 1'b0;
    expect_ev(40, 2, K_SHORT);
    wait_cyc(39);
    key_state[2] = 1'b1;
    wait_cyc(40);
    check("hold2_no_hold", int'(hold_state[2]), 0);
    wait_cyc(50);
    drain();

    // Keys 0 and 1 together: simultaneous short pulses at 9
    do_reset();
    key_state[1:0] = 2'b00;
    expect_ev(9, 0, K_SHORT);
    expect_ev(9, 1, K_SHORT);
    wait_cyc(8);
    key_state[1:0] = 2'b11;
    wait_cyc(15);
    drain();

    // Reset while key0 is in HOLD and still pressed; a fresh long follows
    do_reset();
    key_state[0] = 1'b0;
    expect_ev(40, 0, K_LONG);
    wait_cyc(44);
    check("hold0_before_rst", int'(hold_state[0]), 1);
    rst_in = 1'b1;
    @(negedge clk_in);
    check_all_zero("midrst");
    rst_in = 1'b0;
    expect_ev(40, 0, K_LONG);
    wait_cyc(39);
    check("hold0_after_rst", int'(hold_state[0]), 0);
    wait_cyc(45);
    check("hold0_relong", int'(hold_state[0]), 1);
    key_state[0] = 1'b1;
    wait_cyc(50);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
